// File: rtl/recip_divider_pkg.sv
// Shared types and constants for the reciprocal divider.
// The optional second Newton-Raphson step is enabled by RECIP_DIVIDER_NR2_EN;
// this package is the same in both builds.
package recip_divider_pkg;

   localparam int DATA_W = 16;
   localparam int IDX_W  = 7;
   localparam int FRAC_W = 18;
   localparam int LZC_W  = 4;

   // 2.0 with FRAC_W fractional bits, wide enough to hold 2 - m*x without wrap
   localparam logic [FRAC_W+2:0] TWO_Q = {2'b01, {(FRAC_W + 1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_NR1,
      S_NR2,
      S_MUL,
      S_CORR,
      S_DONE
   } state_t;

   // round(2^30 / (2^15 + idx*2^8)) as Q1.15; only ever evaluated on constants
   function automatic logic [DATA_W-1:0] seed_of(input int idx);
      longint den;
      longint num;
      den = (longint'(1) << (DATA_W - 1)) + (longint'(idx) << (DATA_W - 1 - IDX_W));
      num = longint'(1) << (2 * (DATA_W - 1));
      return DATA_W'((num + den / 2) / den);
   endfunction

endpackage

// File: rtl/recip_divider_seed.sv
// Normalize-and-seed: leading-zero count of d, normalized divisor m = d<<s,
// and the Q1.15 reciprocal seed looked up from the top bits below m's MSB.
module recip_seed
   import recip_divider_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   output logic [LZC_W-1:0]  lzc,
   output logic [DATA_W-1:0] m,
   output logic [DATA_W-1:0] seed
);

   logic [DATA_W-1:0] seed_rom [2**IDX_W];

   for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rom
      assign seed_rom[g] = seed_of(g);
   end

   // highest set bit wins, giving the leading-zero count (d==0 never reaches here)
   always_comb begin
      lzc = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (d[i]) lzc = LZC_W'(DATA_W - 1 - i);
      end
   end

   assign m    = d << lzc;
   assign seed = seed_rom[m[DATA_W-2 -: IDX_W]];

endmodule

// File: rtl/recip_divider.sv
// Sequenced unsigned 16-bit divider: reciprocal seed, Newton-Raphson refine,
// multiply, then +/-1 quotient correction against the exact remainder.
// Define RECIP_DIVIDER_NR2_EN to add a second Newton-Raphson iteration.
//
// state | meaning
// IDLE  | ready for a request; d==0 jumps straight to DONE
// SEED  | normalize d, load reciprocal seed
// NR1   | first Newton-Raphson refinement of x
// NR2   | second refinement (RECIP_DIVIDER_NR2_EN builds only)
// MUL   | q0 = n*x scaled back by the normalization shift
// CORR  | nudge q by one until 0 <= n-q*d < d, bounded by CORR_MAX
// DONE  | result held until the consumer takes it
module recip_divider
   import recip_divider_pkg::*;
#(
   parameter int CORR_MAX = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_dividend,
   input  logic [DATA_W-1:0] i_divisor,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_quotient,
   output logic [DATA_W-1:0] o_remainder,
   output logic              o_dz,
   output logic              o_err
);

   localparam int CNT_W = (CORR_MAX < 1) ? 1 : $clog2(CORR_MAX + 1);
   localparam int XW    = FRAC_W + 1;
   localparam int MX_W  = DATA_W + XW;
   localparam int E_W   = FRAC_W + 3;
   localparam int XE_W  = XW + E_W;
   localparam int NX_W  = DATA_W + XW;
   // remainder is kept wider than the bare 18 bits so a large q*d overshoot
   // can never alias into a plausible value
   localparam int RW    = 2 * DATA_W + 2;

   state_t state_q, state_d;

   logic [DATA_W-1:0] n_q, d_q, m_q, q_q;
   logic [LZC_W-1:0]  s_q;
   logic [XW-1:0]     x_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] quo_q, rem_q;
   logic              dz_q, err_q;

   logic [LZC_W-1:0]  s_seed;
   logic [DATA_W-1:0] m_seed, x0_seed;

   logic [MX_W-1:0]   mx_full;
   logic [E_W-1:0]    mx_p, e_nr;
   logic [XE_W-1:0]   xe_full;
   logic [XW-1:0]     x_nr;

   logic [NX_W-1:0]   nx_full, q_full;
   logic [5:0]        q_sh;
   logic [DATA_W-1:0] q_sat;

   logic [RW-1:0]     qd, r_w;
   logic              r_neg, r_big, need_adj, cnt_tc;

   recip_seed u_seed (
      .d    (d_q),
      .lzc  (s_seed),
      .m    (m_seed),
      .seed (x0_seed)
   );

   // Newton-Raphson step x*(2 - m*x); every product truncated, widths sized so nothing wraps
   always_comb begin
      mx_full = MX_W'(m_q) * MX_W'(x_q);
      mx_p    = E_W'(mx_full >> (DATA_W - 1));
      e_nr    = TWO_Q - mx_p;
      xe_full = XE_W'(x_q) * XE_W'(e_nr);
      x_nr    = XW'(xe_full >> FRAC_W);
   end

   // first quotient estimate, undoing both the Q-format and the normalization shift
   always_comb begin
      nx_full = NX_W'(n_q) * NX_W'(x_q);
      q_sh    = 6'(FRAC_W + DATA_W - 1) - {2'b00, s_q};
      q_full  = nx_full >> q_sh;
      q_sat   = (q_full[NX_W-1:DATA_W] != '0) ? '1 : q_full[DATA_W-1:0];
   end

   // exact remainder of the current guess; sign bit flags an over-estimate
   always_comb begin
      qd       = RW'(q_q) * RW'(d_q);
      r_w      = RW'(n_q) - qd;
      r_neg    = r_w[RW-1];
      r_big    = !r_neg && (r_w >= RW'(d_q));
      need_adj = r_neg || r_big;
      cnt_tc   = (cnt_q == '0);
   end

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (i_valid) state_d = (i_divisor == '0) ? S_DONE : S_SEED;
         S_SEED: state_d = S_NR1;
`ifdef RECIP_DIVIDER_NR2_EN
         S_NR1:  state_d = S_NR2;
         S_NR2:  state_d = S_MUL;
`else
         S_NR1:  state_d = S_MUL;
`endif
         S_MUL:  state_d = S_CORR;
         S_CORR: if (!(need_adj && !cnt_tc)) state_d = S_DONE;
         S_DONE: if (i_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath registers; result registers only change on the way into DONE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         n_q   <= '0;
         d_q   <= '0;
         m_q   <= '0;
         s_q   <= '0;
         x_q   <= '0;
         q_q   <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dz_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  n_q <= i_dividend;
                  d_q <= i_divisor;
                  if (i_divisor == '0) begin
                     quo_q <= '1;
                     rem_q <= i_dividend;
                     dz_q  <= 1'b1;
                     err_q <= 1'b0;
                  end
               end
            end
            S_SEED: begin
               s_q <= s_seed;
               m_q <= m_seed;
               x_q <= XW'(x0_seed) << (FRAC_W - (DATA_W - 1));
            end
            S_NR1, S_NR2: x_q <= x_nr;
            S_MUL: begin
               q_q   <= q_sat;
               cnt_q <= CNT_W'(CORR_MAX);
            end
            S_CORR: begin
               if (need_adj && !cnt_tc) begin
                  q_q   <= r_neg ? q_q - 1'b1 : q_q + 1'b1;
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  quo_q <= q_q;
                  rem_q <= r_w[DATA_W-1:0];
                  dz_q  <= 1'b0;
                  err_q <= need_adj;
               end
            end
            default: ;
         endcase
      end
   end

   // ready is masked by reset so it is low while reset is held and high right after release
   assign o_ready     = (state_q == S_IDLE) && i_rst_n;
   assign o_valid     = (state_q == S_DONE);
   assign o_quotient  = quo_q;
   assign o_remainder = rem_q;
   assign o_dz        = dz_q;
   assign o_err       = err_q;

endmodule
